noliner_cfg_arbiter: RTL and testbench
======================================

# noliner_cfg_arbiter

Shares the AXI4-Lite register port of the Exin_noliner2 slave (four 32-bit registers at offsets 0x0, 0x4, 0x8, 0xC) between NUM_REQ on-chip requesters. Each requester issues single-word read or write commands on a simple valid/ready port. The block round-robin arbitrates, sequences exactly one AXI4-Lite transaction at a time on its master port, and returns the read data and response to the winning requester.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 4, byte-address width on both sides
- DATA_WIDTH, 32, register width (fixed 32)
- ACLK  in  1  single clock for all logic
- ARESET  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  command pending, per requester
- req_ready  out  NUM_REQ  command accepted; one-hot or zero
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened byte addresses
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owner
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP of the completed transaction
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master; widths ADDR_WIDTH, 3, DATA_WIDTH, DATA_WIDTH/8, 2

## Operation
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, DONE.
- IDLE: if any req_valid, the round-robin pick (search starts at last_grant+1, wraps) gets req_ready=1 for one cycle. The command is latched, and the next state is WR_ADDR or RD_ADDR per req_we.
- WR_ADDR: AWVALID and WVALID are asserted together. Each deasserts independently on its own handshake. Go to WR_RESP once both handshakes have completed (same or different cycles).
- WR_RESP: BREADY=1. On BVALID, latch BRESP and go to DONE.
- RD_ADDR: ARVALID=1 until ARREADY, then go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, latch RDATA/RRESP and go to DONE.
- DONE: rsp_valid[owner]=1 for exactly one cycle. last_grant is set to owner. Next state is IDLE.
- Address: AWADDR/ARADDR = {addr[ADDR_WIDTH-1:2],2'b00}; the low two bits are ignored. WSTRB is all ones; AWPROT=ARPROT=3'b000.
- A requester may hold req_valid across its own completion. Its next command is accepted no earlier than the next IDLE, and only if the round-robin pick selects it.
- Requester-side inputs are sampled only in the IDLE accept cycle. Changes after acceptance are ignored.
- SLVERR/DECERR are passed through in rsp_resp unmodified. No retry.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, all M_AXI VALID/READY=0, last_grant=NUM_REQ-1 (so requester 0 wins first), state=IDLE.
- ARESET asserted mid-transaction: all outputs return to reset values at the next edge and the transaction is abandoned. The slave shares this reset.
- All AXI outputs are registered.
- Zero-wait slave, write: accept at cycle 0, AW/W valid at 1, B handshake at 2, rsp_valid at 3, IDLE at 4. Next accept is possible at 4.
- Read has the same latency (AR at 1, R at 2, rsp_valid at 3).
- VALIDs, once asserted, stay high until their handshake and do not depend on READY (AXI rule).
- Simultaneous req_valid from all requesters: grants rotate 0,1,…,NUM_REQ-1,0.

## Structure
- Package noliner_cfg_pkg: state enum (cfg_state_t), AXI response codes (RESP_OKAY, RESP_SLVERR, RESP_DECERR), and register offset constants REG0..REG3 = 0x0/0x4/0x8/0xC.
- Sub-module noliner_rr_arbiter: combinational round-robin pick from a request vector and last_grant. It returns a one-hot grant and a grant index.
- The FSM and datapath latches live in the top module.

## Test plan
- Requester 0 writes 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then reads them back. Expected: rdata 0x1..0x4, rsp_resp=0, each write rsp_valid exactly 3 cycles after accept with a zero-wait slave.
- Both requesters hold req_valid continuously, req0 writing 0xA5 to 0x0 and req1 reading 0x4. Expected: grants alternate 0,1,0,1 and no AXI channel carries two outstanding transactions.
- Slave holds AWREADY low 4 cycles while WREADY is immediate. Expected: WVALID drops after 1 cycle, AWVALID holds 5 cycles, BREADY only after both handshakes.
- req_addr=0x6, write 0x55. Expected: AWADDR=0x4, WSTRB=0xF.
- Slave returns RRESP=SLVERR with RDATA=0xDEAD. Expected: rsp_resp=2, rsp_rdata=0xDEAD, FSM back in IDLE.
- ARESET pulsed while in WR_RESP. Expected: next cycle has all VALID/READY=0 and no rsp_valid. A subsequent write completes normally.

Source files
------------

// File: rtl/noliner_cfg_pkg.sv
// Shared types and constants for the noliner2 register-port arbiter.
// Holds the FSM state encoding, AXI response codes and the slave register map.
package noliner_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_RESP,
      ST_DONE
   } cfg_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [3:0] REG0 = 4'h0;
   localparam logic [3:0] REG1 = 4'h4;
   localparam logic [3:0] REG2 = 4'h8;
   localparam logic [3:0] REG3 = 4'hC;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/noliner_rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_grant_i and wraps.
// Zero latency; no backpressure of its own, the caller decides when a pick is used.
module noliner_rr_arbiter
   import noliner_cfg_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_grant_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               gnt_vld_o
);

   logic [31:0] cand;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      cand      = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = (32'(last_grant_i) + off) % NUM_REQ;
         if (!gnt_vld_o && req_i[cand[IDX_W-1:0]]) begin
            gnt_vld_o                = 1'b1;
            gnt_o[cand[IDX_W-1:0]]   = 1'b1;
            gnt_idx_o                = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/noliner_cfg_arbiter.sv
// Shares one AXI4-Lite master among NUM_REQ requesters, one transaction at a time.
// Zero-wait slave: accept at 0, AXI at 1, response at 2, rsp_valid at 3; requesters wait while busy.
module noliner_cfg_arbiter
   import noliner_cfg_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic [1:0]                    rsp_resp,
   output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
   output logic [2:0]                    M_AXI_AWPROT,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);

   localparam int unsigned IDX_W = idx_width(NUM_REQ);

   cfg_state_t            state_q, state_d;
   logic [IDX_W-1:0]      owner_q, owner_d;
   logic [IDX_W-1:0]      last_q, last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  bready_q, bready_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;

   logic [NUM_REQ-1:0]    gnt;
   logic [IDX_W-1:0]      gnt_idx;
   logic                  gnt_vld;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [NUM_REQ-1:0]    owner_onehot;

   noliner_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i        (req_valid),
      .last_grant_i (last_q),
      .gnt_o        (gnt),
      .gnt_idx_o    (gnt_idx),
      .gnt_vld_o    (gnt_vld)
   );

   assign req_ready    = (state_q == ST_IDLE && !ARESET) ? gnt : '0;
   assign sel_addr     = req_addr[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign owner_onehot = NUM_REQ'(1) << owner_q;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      resp_d      = resp_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               owner_d = gnt_idx;
               addr_d  = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
               wdata_d = req_wdata[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
               if (req_we[gnt_idx]) begin
                  state_d   = ST_WR_ADDR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = ST_RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end
         ST_WR_ADDR: begin
            // AW and W retire independently; B is only accepted once both are gone
            if (M_AXI_AWREADY) awvalid_d = 1'b0;
            if (M_AXI_WREADY)  wvalid_d  = 1'b0;
            if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
               state_d  = ST_WR_RESP;
               bready_d = 1'b1;
            end
         end
         ST_WR_RESP: begin
            if (M_AXI_BVALID) begin
               bready_d    = 1'b0;
               resp_d      = M_AXI_BRESP;
               rdata_d     = '0;
               rsp_valid_d = owner_onehot;
               state_d     = ST_DONE;
            end
         end
         ST_RD_ADDR: begin
            if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_RESP;
            end
         end
         ST_RD_RESP: begin
            if (M_AXI_RVALID) begin
               rready_d    = 1'b0;
               resp_d      = M_AXI_RRESP;
               rdata_d     = M_AXI_RDATA;
               rsp_valid_d = owner_onehot;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            last_d  = owner_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         last_q      <= IDX_W'(NUM_REQ - 1);
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         resp_q      <= RESP_OKAY;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_noliner_cfg_arbiter.sv
// Bench for noliner_cfg_arbiter: AXI4-Lite slave with stall knobs, directed scenarios,
// then random traffic checked every cycle against a channel-level model.
module tb_noliner_cfg_arbiter;

   localparam int N  = 3;
   localparam int AW = 4;
   localparam int DW = 32;

   logic ACLK = 1'b0;
   logic ARESET = 1'b1;
   always #5 ACLK = ~ACLK;

   logic [N-1:0]    req_valid = '0, req_we = '0, req_ready, rsp_valid;
   logic [AW-1:0]   raddr [N];
   logic [DW-1:0]   rwdata [N];
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_resp;
   logic [AW-1:0]   M_AXI_AWADDR, M_AXI_ARADDR;
   logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
   logic            M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
   logic [DW-1:0]   M_AXI_WDATA;
   logic [DW/8-1:0] M_AXI_WSTRB;
   logic            M_AXI_AWREADY = 0, M_AXI_WREADY = 0, M_AXI_BVALID = 0, M_AXI_ARREADY = 0, M_AXI_RVALID = 0;
   logic [1:0]      M_AXI_BRESP = 0, M_AXI_RRESP = 0;
   logic [DW-1:0]   M_AXI_RDATA = 0;

   always_comb begin
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW]  = raddr[i];
         req_wdata[i*DW +: DW] = rwdata[i];
      end
   end

   noliner_cfg_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
      .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
      .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
      .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
      .M_AXI_RREADY(M_AXI_RREADY)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // slave knobs
   int  aw_stall = 0, w_stall = 0, ar_stall = 0, b_lat = 0, r_lat = 0;
   bit  wr_err = 0, rd_err = 0;

   // negedge snapshot: what the next posedge will see
   bit            s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs, s_aw_wait, s_w_wait, s_ar_wait;
   logic [N-1:0]  s_acc = '0;
   logic [AW-1:0] s_awaddr, s_araddr;
   logic [DW-1:0] s_wdata;

   // AXI4-Lite slave: four registers, acts at posedge+1 on the handshakes of the last edge
   logic [31:0] sregs [4] = '{default: 32'h0};
   bit          aw_got = 0, w_got = 0, ar_got = 0, b_pend = 0;
   logic [AW-1:0] sl_awaddr, sl_araddr;
   logic [DW-1:0] sl_wdata;
   int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_cnt = 0, r_cnt = 0;

   always @(posedge ACLK) begin
      #1;
      if (ARESET) begin
         aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0;
         aw_wait = 0; w_wait = 0; ar_wait = 0;
         M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
         M_AXI_BVALID = 0; M_AXI_RVALID = 0;
      end else begin
         if (s_aw_hs) begin aw_got = 1; sl_awaddr = s_awaddr; aw_wait = 0; end
         else if (s_aw_wait) aw_wait++;
         if (s_w_hs) begin w_got = 1; sl_wdata = s_wdata; w_wait = 0; end
         else if (s_w_wait) w_wait++;
         if (s_ar_hs) begin ar_got = 1; sl_araddr = s_araddr; ar_wait = 0; r_cnt = 0; end
         else if (s_ar_wait) ar_wait++;
         if (s_b_hs) M_AXI_BVALID = 0;
         if (s_r_hs) M_AXI_RVALID = 0;
         if (aw_got && w_got) begin
            sregs[sl_awaddr[3:2]] = sl_wdata;
            aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
         end
         if (b_pend) begin
            if (b_cnt >= b_lat) begin
               M_AXI_BVALID = 1; M_AXI_BRESP = wr_err ? 2'b10 : 2'b00; b_pend = 0;
            end else b_cnt++;
         end
         if (ar_got) begin
            if (r_cnt >= r_lat) begin
               M_AXI_RVALID = 1;
               M_AXI_RDATA  = rd_err ? 32'hDEAD : sregs[sl_araddr[3:2]];
               M_AXI_RRESP  = rd_err ? 2'b10 : 2'b00;
               ar_got = 0;
            end else r_cnt++;
         end
         M_AXI_AWREADY = (aw_wait >= aw_stall);
         M_AXI_WREADY  = (w_wait >= w_stall);
         M_AXI_ARREADY = (ar_wait >= ar_stall);
      end
   end

   // behavioural model: one command in flight, channel-level progress flags
   logic [31:0] mirror [4] = '{default: 32'h0};
   bit          m_idle = 1, m_busy = 0, m_rsp_due = 0, m_we = 0, m_zw = 0;
   bit          m_aw_done = 0, m_w_done = 0, m_ar_done = 0;
   int          m_owner = 0, m_last = N - 1, m_acc_cyc = 0, cyc = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0, m_exp_rdata = '0;
   logic [1:0]  m_exp_resp = '0;

   // observations for the directed checks
   int          grant_q[$];
   int          rsp_cnt = 0, last_lat = 0, awv_cyc = 0, wv_cyc = 0;
   logic [DW-1:0] last_rdata = '0;
   logic [1:0]  last_resp = '0;
   logic [AW-1:0] last_awaddr = '0;
   logic [3:0]  last_wstrb = '0;

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   always @(negedge ACLK) begin
      logic [N-1:0] exp_rdy, exp_rsp;
      bit bw, br, knobs0;
      int p;
      cyc++;
      s_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;  s_aw_wait = M_AXI_AWVALID && !M_AXI_AWREADY;
      s_w_hs  = M_AXI_WVALID && M_AXI_WREADY;    s_w_wait  = M_AXI_WVALID && !M_AXI_WREADY;
      s_ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;  s_ar_wait = M_AXI_ARVALID && !M_AXI_ARREADY;
      s_b_hs  = M_AXI_BVALID && M_AXI_BREADY;
      s_r_hs  = M_AXI_RVALID && M_AXI_RREADY;
      s_acc   = req_valid & req_ready;
      s_awaddr = M_AXI_AWADDR; s_araddr = M_AXI_ARADDR; s_wdata = M_AXI_WDATA;

      p = rr_pick(req_valid, m_last);
      exp_rdy = '0;
      if (!ARESET && m_idle && p >= 0) exp_rdy[p] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      exp_rsp = '0;
      if (m_rsp_due) exp_rsp[m_owner] = 1'b1;
      chk("rsp_valid", rsp_valid, exp_rsp);
      if (m_rsp_due) begin
         chk("rsp_rdata", rsp_rdata, m_exp_rdata);
         chk("rsp_resp", rsp_resp, m_exp_resp);
         last_lat = cyc - m_acc_cyc;
         if (m_zw) chk("rsp_latency", last_lat, 3);
         last_rdata = rsp_rdata; last_resp = rsp_resp; rsp_cnt++;
      end
      bw = m_busy && m_we;
      br = m_busy && !m_we;
      chk("AWVALID", M_AXI_AWVALID, bw && !m_aw_done);
      chk("WVALID",  M_AXI_WVALID,  bw && !m_w_done);
      chk("BREADY",  M_AXI_BREADY,  bw && m_aw_done && m_w_done);
      chk("ARVALID", M_AXI_ARVALID, br && !m_ar_done);
      chk("RREADY",  M_AXI_RREADY,  br && m_ar_done);
      if (M_AXI_AWVALID) begin
         chk("AWADDR", M_AXI_AWADDR, (m_addr / 4) * 4);
         chk("AWPROT", M_AXI_AWPROT, 0);
         last_awaddr = M_AXI_AWADDR; awv_cyc++;
      end
      if (M_AXI_WVALID) begin
         chk("WDATA", M_AXI_WDATA, m_wdata);
         chk("WSTRB", M_AXI_WSTRB, 4'hF);
         last_wstrb = M_AXI_WSTRB; wv_cyc++;
      end
      if (M_AXI_ARVALID) begin
         chk("ARADDR", M_AXI_ARADDR, (m_addr / 4) * 4);
         chk("ARPROT", M_AXI_ARPROT, 0);
      end

      knobs0 = (aw_stall == 0 && w_stall == 0 && ar_stall == 0 && b_lat == 0 && r_lat == 0);
      if (ARESET) begin
         m_idle = 1; m_busy = 0; m_rsp_due = 0; m_last = N - 1;
      end else if (m_rsp_due) begin
         m_rsp_due = 0; m_idle = 1; m_last = m_owner;
      end else if (m_idle) begin
         if (p >= 0) begin
            m_idle = 0; m_busy = 1; m_owner = p; grant_q.push_back(p);
            m_we = req_we[p]; m_addr = raddr[p]; m_wdata = rwdata[p];
            m_aw_done = 0; m_w_done = 0; m_ar_done = 0;
            m_acc_cyc = cyc; m_zw = knobs0; awv_cyc = 0; wv_cyc = 0;
            if (m_we) begin
               mirror[m_addr / 4] = m_wdata;
               m_exp_rdata = '0;
               m_exp_resp  = wr_err ? 2'b10 : 2'b00;
            end else begin
               m_exp_rdata = rd_err ? 32'hDEAD : mirror[m_addr / 4];
               m_exp_resp  = rd_err ? 2'b10 : 2'b00;
            end
         end
      end else begin
         if (!knobs0) m_zw = 0;
         if (s_aw_hs) m_aw_done = 1;
         if (s_w_hs)  m_w_done  = 1;
         if (s_ar_hs) m_ar_done = 1;
         if ((m_we && s_b_hs) || (!m_we && s_r_hs)) begin
            m_busy = 0; m_rsp_due = 1;
         end
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #2;
   endtask

   task automatic wait_rsp(input int target, input string nm);
      int t = 0;
      while (rsp_cnt < target && t < 300) begin tick(); t++; end
      if (rsp_cnt < target) chk(nm, 0, 1);
   endtask

   task automatic do_op(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int t = 0;
      int n0;
      n0 = rsp_cnt;
      req_valid[i] = 1'b1; req_we[i] = we; raddr[i] = a; rwdata[i] = d;
      do begin tick(); t++; end while (!s_acc[i] && t < 300);
      if (!s_acc[i]) chk("accept_timeout", 0, 1);
      req_valid[i] = 1'b0;
      wait_rsp(n0 + 1, "rsp_timeout");
      tick();
   endtask

   task automatic pulse_reset();
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      tick();
   endtask

   initial begin
      int n0, t;
      for (int i = 0; i < N; i++) begin raddr[i] = '0; rwdata[i] = '0; end
      repeat (3) tick();
      @(negedge ACLK);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_resp", rsp_resp, 0);
      chk("rst_axi_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
      chk("rst_axi_readys", {M_AXI_BREADY, M_AXI_RREADY}, 0);
      tick();
      ARESET = 1'b0;
      tick();

      // write-then-readback through requester 0, zero-wait slave
      for (int k = 0; k < 4; k++) begin
         do_op(0, 1'b1, AW'(4 * k), DW'(k + 1));
         chk("wr_latency", last_lat, 3);
      end
      for (int k = 0; k < 4; k++) begin
         do_op(0, 1'b0, AW'(4 * k), '0);
         chk("readback", last_rdata, DW'(k + 1));
         chk("readback_resp", last_resp, 0);
      end

      // two requesters holding valid: grants alternate starting from 0
      pulse_reset();
      grant_q.delete();
      n0 = rsp_cnt;
      req_we[0] = 1'b1; raddr[0] = 4'h0; rwdata[0] = 32'hA5;
      req_we[1] = 1'b0; raddr[1] = 4'h4; rwdata[1] = 32'h0;
      req_valid[0] = 1'b1; req_valid[1] = 1'b1;
      t = 0;
      while (grant_q.size() < 4 && t < 300) begin tick(); t++; end
      req_valid = '0;
      wait_rsp(n0 + 4, "rr_rsp_timeout");
      tick();
      chk("rr_grant_count", grant_q.size(), 4);
      for (int k = 0; k < 4 && k < grant_q.size(); k++) chk("rr_grant", grant_q[k], k % 2);
      chk("rr_last_read", last_rdata, 32'h2);

      // AWREADY held low four cycles, WREADY immediate
      aw_stall = 4;
      do_op(0, 1'b1, 4'h8, 32'h77);
      aw_stall = 0;
      chk("stall_awvalid_cycles", awv_cyc, 5);
      chk("stall_wvalid_cycles", wv_cyc, 1);

      // unaligned address is word-aligned on the bus
      do_op(0, 1'b1, 4'h6, 32'h55);
      chk("unaligned_awaddr", last_awaddr, 4'h4);
      chk("unaligned_wstrb", last_wstrb, 4'hF);

      // slave error passed through, arbiter keeps going
      rd_err = 1;
      do_op(1, 1'b0, 4'h0, '0);
      rd_err = 0;
      chk("slverr_resp", last_resp, 2'b10);
      chk("slverr_rdata", last_rdata, 32'hDEAD);
      do_op(1, 1'b0, 4'h4, '0);
      chk("after_err_read", last_rdata, 32'h55);

      // reset while waiting on B
      b_lat = 6;
      req_valid[0] = 1'b1; req_we[0] = 1'b1; raddr[0] = 4'hC; rwdata[0] = 32'h99;
      t = 0;
      do begin tick(); t++; end while (!s_acc[0] && t < 300);
      req_valid[0] = 1'b0;
      t = 0;
      do begin @(negedge ACLK); t++; end while (!M_AXI_BREADY && t < 300);
      chk("reached_wr_resp", M_AXI_BREADY, 1);
      tick();
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("arst_axi_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
      chk("arst_axi_readys", {M_AXI_BREADY, M_AXI_RREADY}, 0);
      chk("arst_rsp_valid", rsp_valid, 0);
      b_lat = 0;
      tick();
      do_op(1, 1'b1, 4'h0, 32'h1234);
      chk("post_reset_wr_resp", last_resp, 0);
      do_op(1, 1'b0, 4'h0, '0);
      chk("post_reset_read", last_rdata, 32'h1234);

      // random traffic from all requesters with random slave stalls
      n0 = rsp_cnt;
      for (int c = 0; c < 1500; c++) begin
         tick();
         if (c % 40 == 0) begin
            if ($urandom_range(1, 0) == 0) begin
               aw_stall = 0; w_stall = 0; ar_stall = 0; b_lat = 0; r_lat = 0;
            end else begin
               aw_stall = $urandom_range(3, 0); w_stall = $urandom_range(3, 0);
               ar_stall = $urandom_range(3, 0); b_lat = $urandom_range(3, 0);
               r_lat = $urandom_range(3, 0);
            end
         end
         for (int i = 0; i < N; i++) begin
            if (s_acc[i] || !req_valid[i]) begin
               if ($urandom_range(1, 0) == 1) begin
                  req_valid[i] = 1'b1;
                  req_we[i]    = 1'($urandom_range(1, 0));
                  raddr[i]     = AW'($urandom_range(15, 0));
                  rwdata[i]    = $urandom;
               end else begin
                  req_valid[i] = 1'b0;
               end
            end
         end
      end
      req_valid = '0;
      t = 0;
      while (!m_idle && t < 300) begin tick(); t++; end
      repeat (3) tick();
      chk("random_progress", (rsp_cnt - n0) > 100, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog: got timeout required completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
